// File: rtl/reset_ctrl_pkg.sv
// reset_ctrl_pkg: shared FSM state encodings, reset-cause codes and cause width for reset_ctrl
package reset_ctrl_pkg;
  localparam int CAUSE_W = 3;
  typedef enum logic [1:0] {HOLD = 2'd0, WAIT_LOCK = 2'd1, RELEASE = 2'd2, RUN = 2'd3} state_t;
  typedef enum logic [CAUSE_W-1:0] {C_POR = 3'd0, C_BTN = 3'd1, C_LOCK = 3'd2, C_WDT = 3'd3, C_SW = 3'd4} cause_t;
endpackage

// File: rtl/rst_debounce.sv
// rst_debounce: 2-FF synchroniser plus CYC-sample level filter; ports clk, reset, i_async (raw level) -> o_level (filtered level)
module rst_debounce #(
  parameter int   CYC     = 16,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level
);
  localparam int CW = $clog2(CYC);
  logic          r_s1, r_s2, r_lvl;
  logic [CW-1:0] r_cnt;
  logic          w_diff, w_done;
  assign w_diff  = r_s2 != r_lvl;
  assign w_done  = w_diff && r_cnt == CW'(CYC - 1);
  assign o_level = r_lvl;
  always_ff @(posedge clk)
    if (reset) begin
      r_s1  <= RST_VAL;
      r_s2  <= RST_VAL;
      r_lvl <= RST_VAL;
      r_cnt <= '0;
    end else begin
      r_s1  <= i_async;
      r_s2  <= r_s1;
      r_cnt <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
      r_lvl <= w_done ? r_s2 : r_lvl;
    end
endmodule

// File: rtl/reset_ctrl.sv
// reset_ctrl: staged multi-domain reset sequencer; ports clk, reset, reset_sw, locked, sw_rst_req, wdt_en, wdt_kick -> domain_reset, all_ready, rst_cause
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int N_DOMAIN     = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int STAGE_GAP    = 8,
  parameter int WDT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_sw,
  input  logic                locked,
  input  logic                sw_rst_req,
  input  logic                wdt_en,
  input  logic                wdt_kick,
  output logic [N_DOMAIN-1:0] domain_reset,
  output logic                all_ready,
  output logic [CAUSE_W-1:0]  rst_cause
);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int IW = $clog2(N_DOMAIN + 1);
  state_t              r_state, w_state_n;
  cause_t              r_cause, w_cause_n, w_cause_t;
  logic [GW-1:0]       r_gap, w_gap_n;
  logic [IW-1:0]       r_idx, w_idx_n;
  logic [N_DOMAIN-1:0] r_dom, w_dom_n;
  logic                r_ready, w_ready_n;
  logic [WDT_W-1:0]    r_wdt, w_wdt_n;
  logic                r_lock_s1, r_lock_s2, r_btn_q;
  logic                w_btn, w_gap_end, w_run;
  logic                w_btn_t, w_lock_t, w_wdt_t, w_sw_t, w_trig;
  rst_debounce #(.CYC(DEBOUNCE_CYC), .RST_VAL(1'b1)) u_btn (
    .clk(clk), .reset(reset), .i_async(reset_sw), .o_level(w_btn)
  );
  assign w_run     = r_state == RUN;
  assign w_gap_end = r_gap == GW'(STAGE_GAP - 1);
  assign w_btn_t   = r_state != HOLD && r_btn_q && !w_btn;
  assign w_lock_t  = (r_state == RELEASE || w_run) && !r_lock_s2;
  assign w_wdt_t   = w_run && wdt_en && !wdt_kick && &r_wdt;
  assign w_sw_t    = w_run && sw_rst_req;
  assign w_trig    = w_btn_t || w_lock_t || w_wdt_t || w_sw_t;
  assign w_cause_t = w_btn_t ? C_BTN : w_lock_t ? C_LOCK : w_wdt_t ? C_WDT : C_SW;
  assign domain_reset = r_dom;
  assign all_ready    = r_ready;
  assign rst_cause    = r_cause;
  always_comb begin
    w_state_n = r_state;
    w_gap_n   = r_gap;
    w_idx_n   = r_idx;
    w_dom_n   = r_dom;
    w_ready_n = r_ready;
    w_cause_n = r_cause;
    w_wdt_n   = (w_run && wdt_en && !wdt_kick) ? r_wdt + 1'b1 : '0;
    case (r_state)
      HOLD: begin
        w_state_n = w_gap_end ? WAIT_LOCK : HOLD;
        w_gap_n   = w_gap_end ? '0 : r_gap + 1'b1;
      end
      WAIT_LOCK: begin
        w_state_n = r_lock_s2 ? RELEASE : WAIT_LOCK;
        w_gap_n   = '0;
        w_idx_n   = '0;
      end
      RELEASE: begin
        w_gap_n = w_gap_end ? '0 : r_gap + 1'b1;
        if (w_gap_end) begin
          w_dom_n = r_dom & ~(N_DOMAIN'(1) << r_idx);
          w_idx_n = r_idx + 1'b1;
          w_state_n = (r_idx == IW'(N_DOMAIN - 1)) ? RUN : RELEASE;
          w_ready_n = r_idx == IW'(N_DOMAIN - 1);
        end
      end
      default: ;
    endcase
    if (w_trig) begin
      w_state_n = HOLD;
      w_gap_n   = '0;
      w_idx_n   = '0;
      w_dom_n   = '1;
      w_ready_n = 1'b0;
      w_cause_n = w_cause_t;
      w_wdt_n   = '0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state   <= HOLD;
      r_cause   <= C_POR;
      r_gap     <= '0;
      r_idx     <= '0;
      r_dom     <= '1;
      r_ready   <= 1'b0;
      r_wdt     <= '0;
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_btn_q   <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_cause   <= w_cause_n;
      r_gap     <= w_gap_n;
      r_idx     <= w_idx_n;
      r_dom     <= w_dom_n;
      r_ready   <= w_ready_n;
      r_wdt     <= w_wdt_n;
      r_lock_s1 <= locked;
      r_lock_s2 <= r_lock_s1;
      r_btn_q   <= w_btn;
    end
endmodule
